// File: rtl/fft_agu_pkg.sv
// fft_consts: shared constants and types for the FFT datapath.
//   DEF_N_POINTS / DEF_LOG2N / DEF_PIPE_LAT : default FFT size, address width
//                                            and read-to-result latency
//   FP_BITS / FRAC_BITS / complex_t         : sample format used by the butterfly
//   agu_state_t                             : sequencing states of fft_agu
package fft_consts;

    localparam int DEF_N_POINTS = 64;
    localparam int DEF_LOG2N    = $clog2(DEF_N_POINTS);
    // 1 cycle synchronous RAM/ROM read + 4 cycle butterfly pipeline
    localparam int DEF_PIPE_LAT = 5;

    localparam int FP_BITS   = 16;
    localparam int FRAC_BITS = 14;

    typedef struct packed {
        logic signed [FP_BITS-1:0] re;
        logic signed [FP_BITS-1:0] im;
    } complex_t;

    typedef enum logic [1:0] {
        AGU_IDLE  = 2'd0,
        AGU_ISSUE = 2'd1,
        AGU_DRAIN = 2'd2,
        AGU_DONE  = 2'd3
    } agu_state_t;

endpackage

// File: rtl/fft_agu_if.sv
// fft_agu_if: memory-side bus of the FFT address generator.
//   rd_en / rd_addr_a / rd_addr_b / tw_idx : sample RAM A/B read and twiddle ROM read
//   wr_en / wr_addr_a / wr_addr_b          : in-place write-back of butterfly results
// master = address generator, slave = RAM/ROM side.
interface fft_agu_if #(
    parameter int LOG2N = fft_consts::DEF_LOG2N
);
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_idx;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;

    modport master (
        output rd_en, rd_addr_a, rd_addr_b, tw_idx,
        output wr_en, wr_addr_a, wr_addr_b
    );

    modport slave (
        input rd_en, rd_addr_a, rd_addr_b, tw_idx,
        input wr_en, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/fft_agu_delay_line.sv
// agu_delay_line: WIDTH x DEPTH shift register with shift enable and async clear.
//   clk, rst_n : clock, asynchronous active-low clear of every stage
//   en         : shift enable (low freezes the whole line)
//   d / q      : line input / output DEPTH enabled cycles later
module agu_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else if (en) begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];
endmodule

// File: rtl/fft_agu.sv
// fft_agu: address generator / sequencer for an in-place radix-2 DIT FFT.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request a full FFT (accepted in IDLE only; latched if stalled)
//   stall      : freezes FSM, counters and write-back delay line
//   bfu_en     : butterfly pipeline enable (= ~stall)
//   bus        : read pair + twiddle index, and delayed write-back pair
//   stage      : stage currently issuing
//   busy       : run in progress (ISSUE/DRAIN)
//   done       : completion pulse
module fft_agu
    import fft_consts::*;
#(
    parameter int N_POINTS = DEF_N_POINTS,
    parameter int LOG2N    = $clog2(N_POINTS),
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stall,
    output logic                       bfu_en,
    fft_agu_if.master                  bus,
    output logic [$clog2(LOG2N)-1:0]   stage,
    output logic                       busy,
    output logic                       done
);
    localparam int HALF_N = N_POINTS / 2;
    localparam int KW     = LOG2N - 1;
    localparam int SW     = $clog2(LOG2N);
    localparam int DW     = $clog2(PIPE_LAT + 1);
    localparam int LW     = 1 + 2 * LOG2N;

    agu_state_t    state, state_nx;
    logic [KW-1:0] k, k_nx;
    logic [SW-1:0] s, s_nx;
    logic [DW-1:0] dcnt, dcnt_nx;
    logic          pend, pend_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= AGU_IDLE;
            k     <= '0;
            s     <= '0;
            dcnt  <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
            s     <= s_nx;
            dcnt  <= dcnt_nx;
            pend  <= pend_nx;
        end
    end

    always_comb begin
        state_nx = state;
        k_nx     = k;
        s_nx     = s;
        dcnt_nx  = dcnt;
        pend_nx  = pend;
        if (stall) begin
            // A start that arrives while frozen is remembered and taken on
            // the first non-stalled cycle.
            if (state == AGU_IDLE && start) pend_nx = 1'b1;
        end else begin
            case (state)
                AGU_IDLE: begin
                    if (start || pend) begin
                        state_nx = AGU_ISSUE;
                        k_nx     = '0;
                        s_nx     = '0;
                        pend_nx  = 1'b0;
                    end
                end
                AGU_ISSUE: begin
                    if (k == KW'(HALF_N - 1)) begin
                        state_nx = AGU_DRAIN;
                        dcnt_nx  = '0;
                    end else begin
                        k_nx = k + KW'(1);
                    end
                end
                AGU_DRAIN: begin
                    // Wait until the last write of this stage has landed so
                    // the next stage never reads stale data.
                    if (dcnt == DW'(PIPE_LAT - 1)) begin
                        if (s == SW'(LOG2N - 1)) begin
                            state_nx = AGU_DONE;
                        end else begin
                            state_nx = AGU_ISSUE;
                            s_nx     = s + SW'(1);
                            k_nx     = '0;
                        end
                    end else begin
                        dcnt_nx = dcnt + DW'(1);
                    end
                end
                AGU_DONE: begin
                    state_nx = AGU_IDLE;
                    s_nx     = '0;
                end
                default: state_nx = AGU_IDLE;
            endcase
        end
    end

    // Butterfly k of stage s: groups of 2*half, p = position inside the group.
    logic [LOG2N-1:0] kx, half, p, base, tw_full, addr_a, addr_b;
    logic [SW:0]      s1;
    logic [SW-1:0]    tsh;
    logic             issuing;

    always_comb begin
        kx      = {1'b0, k};
        half    = LOG2N'(1) << s;
        p       = kx & (half - LOG2N'(1));
        s1      = (SW+1)'(s) + (SW+1)'(1);
        base    = (kx >> s) << s1;
        tsh     = SW'(LOG2N - 1) - s;
        tw_full = p << tsh;
    end

    // Addresses are zero outside ISSUE so idle/reset outputs are all-zero and
    // the delay line fills with zeros during drain.
    assign issuing = (state == AGU_ISSUE);
    assign addr_a  = issuing ? (base | p) : '0;
    assign addr_b  = issuing ? (addr_a + half) : '0;

    assign bus.rd_en     = issuing & ~stall;
    assign bus.rd_addr_a = addr_a;
    assign bus.rd_addr_b = addr_b;
    assign bus.tw_idx    = issuing ? tw_full[LOG2N-2:0] : '0;

    logic [LW-1:0] dl_q;
    logic          wr_v;

    agu_delay_line #(
        .WIDTH (LW),
        .DEPTH (PIPE_LAT)
    ) u_wb_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (~stall),
        .d     ({issuing, addr_a, addr_b}),
        .q     (dl_q)
    );

    assign {wr_v, bus.wr_addr_a, bus.wr_addr_b} = dl_q;
    assign bus.wr_en = wr_v & ~stall;

    assign bfu_en = ~stall;
    assign busy   = (state == AGU_ISSUE) || (state == AGU_DRAIN);
    assign done   = (state == AGU_DONE);
    assign stage  = s;
endmodule
